// File: rtl/cpu_writeback.sv
// Writeback stage of the stack CPU: commits pop/push effects to the operand stack,
// turns taken branches into a one-cycle redirect plus kill shadow, and halts on stack faults.
module cpu_writeback #(
  parameter int          DEPTH       = 16,
  parameter int          PTR_W       = 5,
  parameter int          KILL_SHADOW = 3,
  parameter logic [1:0]  UC_PUSHALU  = 2'd1,
  parameter logic [1:0]  UC_PUSHIMM  = 2'd2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              kill_4a,
  input  logic [31:0]       branch_target_4a,
  input  logic [1:0]        c__to_push_4a,
  input  logic [34:0]       st__to_push_4a,
  input  logic [10:0]       st__to_pop_4a,
  input  logic [31:0]       pc_4a,
  output logic              redirect_5a,
  output logic [31:0]       redirect_pc_5a,
  output logic [34:0]       st__tos_5a,
  output logic [34:0]       st__nos_5a,
  output logic [PTR_W-1:0]  st__depth_5a,
  output logic              halted_5a,
  output logic [1:0]        fault_5a,
  output logic [31:0]       fault_pc_5a
);

  localparam int AW   = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int SH_W = (KILL_SHADOW < 1) ? 1 : $clog2(KILL_SHADOW + 1);
  localparam logic [PTR_W-1:0] P_ONE = 1;
  localparam logic [SH_W-1:0]  S_ONE = 1;

  typedef enum logic [1:0] {S_RUN, S_SHADOW, S_HALT} state_t;

  state_t            state_q;
  logic [SH_W-1:0]   shadow_q;
  logic [PTR_W-1:0]  depth_q;
  logic [34:0]       tos_q, nos_q;
  logic              redirect_q;
  logic [31:0]       redirect_pc_q;
  logic              halted_q;
  logic [1:0]        fault_q;
  logic [31:0]       fault_pc_q;

  logic [34:0]       stack_mem [DEPTH];

  logic              push;
  logic              underflow;
  logic              overflow;
  logic              commit;
  logic [PTR_W-1:0]  base;
  logic [PTR_W-1:0]  base_m1;
  logic [PTR_W-1:0]  base_m2;
  logic [PTR_W-1:0]  depth_d;
  logic [34:0]       tos_d, nos_d;

  assign push      = (c__to_push_4a == UC_PUSHALU) || (c__to_push_4a == UC_PUSHIMM);
  assign underflow = st__to_pop_4a > {{(11-PTR_W){1'b0}}, depth_q};
  // base is only meaningful when there is no underflow; it is the post-pop depth.
  assign base      = depth_q - st__to_pop_4a[PTR_W-1:0];
  assign base_m1   = base - P_ONE;
  assign base_m2   = base - P_ONE - P_ONE;
  assign overflow  = push && (base == PTR_W'(DEPTH));
  assign commit    = (state_q == S_RUN) && !underflow && !overflow;
  assign depth_d   = base + {{(PTR_W-1){1'b0}}, push};

  // New tos/nos are formed from entries below the post-pop depth, which the push never overwrites.
  always_comb begin
    tos_d = '0;
    nos_d = '0;
    if (push) begin
      tos_d = st__to_push_4a;
      if (base != '0) nos_d = stack_mem[AW'(base_m1)];
    end else begin
      if (base != '0)  tos_d = stack_mem[AW'(base_m1)];
      if (base > P_ONE) nos_d = stack_mem[AW'(base_m2)];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && push) stack_mem[AW'(base)] <= st__to_push_4a;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= S_RUN;
      shadow_q      <= '0;
      depth_q       <= '0;
      tos_q         <= '0;
      nos_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      halted_q      <= 1'b0;
      fault_q       <= 2'd0;
      fault_pc_q    <= '0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (underflow) begin
            fault_q    <= 2'd1;
            fault_pc_q <= pc_4a;
            halted_q   <= 1'b1;
            state_q    <= S_HALT;
          end else if (overflow) begin
            fault_q    <= 2'd2;
            fault_pc_q <= pc_4a;
            halted_q   <= 1'b1;
            state_q    <= S_HALT;
          end else begin
            depth_q <= depth_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            if (kill_4a) begin
              redirect_q    <= 1'b1;
              redirect_pc_q <= branch_target_4a;
              shadow_q      <= SH_W'(KILL_SHADOW);
              if (KILL_SHADOW != 0) state_q <= S_SHADOW;
            end
          end
        end
        S_SHADOW: begin
          shadow_q <= shadow_q - S_ONE;
          if (shadow_q == S_ONE) state_q <= S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign redirect_5a    = redirect_q;
  assign redirect_pc_5a = redirect_pc_q;
  assign st__tos_5a     = tos_q;
  assign st__nos_5a     = nos_q;
  assign st__depth_5a   = depth_q;
  assign halted_5a      = halted_q;
  assign fault_5a       = fault_q;
  assign fault_pc_5a    = fault_pc_q;

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
Final pipeline stage of the stack CPU, directly downstream of the memory stage. Consumes the registered 4a bundle and commits each instruction's operand-stack effect to a register-file stack: pops first, then an optional push. Turns kill_4a/branch_target_4a into a one-cycle fetch redirect and squashes wrong-path instructions in the kill shadow. Exports top-of-stack, next-on-stack and depth to decode/execute, and halts on stack overflow or underflow.

Parameters:
DEPTH, 16, number of 35-bit stack entries
PTR_W, 5, depth/pointer width; must satisfy 2^PTR_W > DEPTH
KILL_SHADOW, 3, number of cycles after a kill whose 4a inputs are squashed

Ports:
clk  input  1  clock
rst_b  input  1  asynchronous active-low reset
kill_4a  input  1  taken-branch indication
branch_target_4a  input  32  redirect target, valid when kill_4a=1
c__to_push_4a  input  2  push select; UC_PUSHALU/UC_PUSHIMM push, any other value means no push
st__to_push_4a  input  35  {type[2:0], data[31:0]} to push
st__to_pop_4a  input  11  number of entries to pop (unsigned)
pc_4a  input  32  PC of the 4a instruction
redirect_5a  output  1  one-cycle fetch redirect pulse
redirect_pc_5a  output  32  redirect target
st__tos_5a  output  35  top entry; 35'h0 when depth=0
st__nos_5a  output  35  second entry; 35'h0 when depth<2
st__depth_5a  output  PTR_W  current entry count
halted_5a  output  1  stage has stopped committing
fault_5a  output  2  0 none, 1 underflow, 2 overflow
fault_pc_5a  output  32  pc_4a of the faulting instruction

Behaviour:
- Reset is asynchronous active-low. On reset: state RUN, depth 0, shadow counter 0, all outputs 0. Stack array contents are don't-care.
- Reset mid-operation aborts everything, including an active shadow or HALT.
- All outputs are registered. Effects of a 4a input appear on the *_5a outputs the next cycle.
- States:
  - RUN: commit every cycle.
  - SHADOW: squash inputs.
  - HALT: frozen.
- Commit in RUN, evaluated in this order:
  - pop = st__to_pop_4a; push = 1 when c__to_push_4a is UC_PUSHALU or UC_PUSHIMM.
  - Underflow: pop > depth (full 11-bit compare). Set fault=1, fault_pc=pc_4a, go to HALT. No stack change and no redirect, even if kill_4a=1.
  - Overflow: otherwise, if push and (depth - pop) == DEPTH. Set fault=2, fault_pc=pc_4a, go to HALT. No stack change.
  - Otherwise: new depth = depth - pop + push. A pushed value is written to entry index (depth - pop). Pop and push in the same cycle therefore replace the popped top.
- Kill, committing instruction in RUN:
  - The instruction's own stack effect commits.
  - Next cycle: redirect_5a=1 and redirect_pc_5a=branch_target_4a.
  - Shadow counter loads KILL_SHADOW and state becomes SHADOW; if KILL_SHADOW=0, stay in RUN.
- SHADOW:
  - Inputs have no stack effect, no fault check, and kill_4a is ignored.
  - The counter decrements each cycle; at 1 the stage returns to RUN, so exactly KILL_SHADOW cycles are squashed.
- redirect_5a is 1 for exactly one cycle per honoured kill; otherwise 0. redirect_pc_5a holds its last value.
- HALT:
  - Sticky until reset. halted_5a=1 from the cycle after the fault.
  - Stack, depth and tos/nos stay frozen; redirect_5a stays 0; all inputs are ignored.
- tos/nos/depth reflect post-commit state and are readable combinationally by consumers from the registers.
- Full stack with pop≥1 and push in the same cycle is legal.
- Empty stack with pop=0 and push is legal.
- Pop of exactly depth is legal and leaves depth=0.

Test Plan:
- Reset, then push UC_PUSHIMM 35'h1_0000_0005, then UC_PUSHALU 35'h0_0000_0007 -> depth=2, tos=35'h0_0000_0007, nos=35'h1_0000_0005. Each change is visible one cycle after its input.
- Depth 2, pop=2 with push 35'h0_0000_000C -> depth=1, tos=35'h0_0000_000C, nos=0.
- kill_4a=1 with branch_target_4a=32'h0000_0100, pop=1 -> next cycle redirect_5a=1 for one cycle, redirect_pc_5a=32'h100, depth decremented. The following 3 cycles of pushes (and a kill_4a=1 among them) have no effect; the 4th-cycle push commits.
- Depth 1, pop=2, pc_4a=32'h40 -> fault_5a=1, fault_pc_5a=32'h40, halted_5a=1, depth stays 1. Later pushes are ignored until rst_b pulse, after which everything reads 0.
- Fill 16 entries; push with pop=0 -> fault_5a=2, depth=16. After reset, fill 16 and push with pop=1 -> no fault, depth=16, tos=new value.
- Assert rst_b low asynchronously mid-shadow (counter=2) -> outputs 0 immediately; first input after release commits normally.
